// File: rtl/ex_mem_skid_reg_if.sv
// rtl/ex_mem_skid_reg_if.sv - EX->MEM valid/ready handshake bundle
// Signal prefixes are from the pipeline register's point of view.
interface ex_mem_skid_reg_if #(
  parameter int DATA_W  = 140,
  parameter int INSTR_W = 32
);
  logic               i_up_vld;
  logic               o_up_rdy;
  logic [INSTR_W-1:0] i_up_instr;
  logic [DATA_W-1:0]  i_up_data;
  logic               o_dn_vld;
  logic               i_dn_rdy;
  logic [INSTR_W-1:0] o_dn_instr;
  logic [DATA_W-1:0]  o_dn_data;

  modport slave (
    input  i_up_vld, i_up_instr, i_up_data, i_dn_rdy,
    output o_up_rdy, o_dn_vld, o_dn_instr, o_dn_data
  );

  modport master (
    output i_up_vld, i_up_instr, i_up_data, i_dn_rdy,
    input  o_up_rdy, o_dn_vld, o_dn_instr, o_dn_data
  );
endinterface

// File: rtl/ex_mem_skid_reg.sv
// rtl/ex_mem_skid_reg.sv - EX->MEM pipeline register with one-entry skid buffer
// All outputs come straight from flops, so o_up_rdy never depends on i_dn_rdy combinationally.
module ex_mem_skid_reg #(
  parameter int                 DATA_W    = 140,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013,
  parameter int                 CNT_W     = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_flush,
  ex_mem_skid_reg_if.slave   bus,
  output logic [1:0]         o_occ,
  output logic [CNT_W-1:0]   o_stall_cnt,
  output logic [CNT_W-1:0]   o_flush_cnt
);
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             r_state;
  logic               r_up_rdy;
  logic               r_dn_vld;
  logic [1:0]         r_occ;
  logic [INSTR_W-1:0] r_main_instr;
  logic [DATA_W-1:0]  r_main_data;
  logic [INSTR_W-1:0] r_skid_instr;
  logic [DATA_W-1:0]  r_skid_data;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic [CNT_W-1:0]   r_flush_cnt;

  logic w_up_fire;
  logic w_dn_fire;
  logic w_stall;
  logic w_flush_hit;

  assign w_up_fire   = bus.i_up_vld & r_up_rdy;
  assign w_dn_fire   = r_dn_vld & bus.i_dn_rdy;
  assign w_stall     = r_dn_vld & ~bus.i_dn_rdy;
  assign w_flush_hit = i_flush & ((r_state != S_EMPTY) | bus.i_up_vld);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_EMPTY;
      r_up_rdy     <= 1'b1;
      r_dn_vld     <= 1'b0;
      r_occ        <= 2'd0;
      r_main_instr <= NOP_INSTR;
      r_main_data  <= '0;
      r_skid_instr <= '0;
      r_skid_data  <= '0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != CNT_MAX))
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      if (w_flush_hit && (r_flush_cnt != CNT_MAX))
        r_flush_cnt <= r_flush_cnt + CNT_ONE;

      // Flush wins over any same-cycle up beat; a same-cycle down beat already left.
      if (i_flush) begin
        r_state      <= S_EMPTY;
        r_up_rdy     <= 1'b1;
        r_dn_vld     <= 1'b0;
        r_occ        <= 2'd0;
        r_main_instr <= NOP_INSTR;
        r_main_data  <= '0;
        r_skid_instr <= '0;
        r_skid_data  <= '0;
      end else begin
        case (r_state)
          S_EMPTY: begin
            if (w_up_fire) begin
              r_state      <= S_ONE;
              r_dn_vld     <= 1'b1;
              r_occ        <= 2'd1;
              r_main_instr <= bus.i_up_instr;
              r_main_data  <= bus.i_up_data;
            end
          end
          S_ONE: begin
            if (w_up_fire && w_dn_fire) begin
              r_main_instr <= bus.i_up_instr;
              r_main_data  <= bus.i_up_data;
            end else if (w_up_fire) begin
              r_state      <= S_FULL;
              r_up_rdy     <= 1'b0;
              r_occ        <= 2'd2;
              r_skid_instr <= bus.i_up_instr;
              r_skid_data  <= bus.i_up_data;
            end else if (w_dn_fire) begin
              r_state      <= S_EMPTY;
              r_dn_vld     <= 1'b0;
              r_occ        <= 2'd0;
            end
          end
          S_FULL: begin
            if (w_dn_fire) begin
              r_state      <= S_ONE;
              r_up_rdy     <= 1'b1;
              r_occ        <= 2'd1;
              r_main_instr <= r_skid_instr;
              r_main_data  <= r_skid_data;
            end
          end
          default: begin
            r_state  <= S_EMPTY;
            r_up_rdy <= 1'b1;
            r_dn_vld <= 1'b0;
            r_occ    <= 2'd0;
          end
        endcase
      end
    end
  end

  assign bus.o_up_rdy   = r_up_rdy;
  assign bus.o_dn_vld   = r_dn_vld;
  assign bus.o_dn_instr = r_main_instr;
  assign bus.o_dn_data  = r_main_data;
  assign o_occ          = r_occ;
  assign o_stall_cnt    = r_stall_cnt;
  assign o_flush_cnt    = r_flush_cnt;
endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// tb/tb_ex_mem_skid_reg.sv - bench for ex_mem_skid_reg against a two-deep queue model
// A second instance with 4-bit counters shares the stimulus to exercise saturation.
module tb_ex_mem_skid_reg;
  localparam int                 DATA_W  = 140;
  localparam int                 INSTR_W = 32;
  localparam int                 CNT_W   = 16;
  localparam int                 CNT_W_N = 4;
  localparam logic [INSTR_W-1:0] NOP     = 32'h0000_0013;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [DATA_W-1:0]  data;
  } beat_t;

  logic               clk      = 1'b0;
  logic               rst      = 1'b1;
  logic               flush    = 1'b0;
  logic               up_vld   = 1'b0;
  logic               dn_rdy   = 1'b0;
  logic [INSTR_W-1:0] up_instr = '0;
  logic [DATA_W-1:0]  up_data  = '0;

  logic [1:0]         occ_a, occ_b;
  logic [CNT_W-1:0]   stall_a, flush_a;
  logic [CNT_W_N-1:0] stall_b, flush_b;

  ex_mem_skid_reg_if #(.DATA_W(DATA_W), .INSTR_W(INSTR_W)) bus_a ();
  ex_mem_skid_reg_if #(.DATA_W(DATA_W), .INSTR_W(INSTR_W)) bus_b ();

  assign bus_a.i_up_vld   = up_vld;
  assign bus_a.i_up_instr = up_instr;
  assign bus_a.i_up_data  = up_data;
  assign bus_a.i_dn_rdy   = dn_rdy;
  assign bus_b.i_up_vld   = up_vld;
  assign bus_b.i_up_instr = up_instr;
  assign bus_b.i_up_data  = up_data;
  assign bus_b.i_dn_rdy   = dn_rdy;

  ex_mem_skid_reg #(.DATA_W(DATA_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP), .CNT_W(CNT_W)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_flush(flush), .bus(bus_a),
    .o_occ(occ_a), .o_stall_cnt(stall_a), .o_flush_cnt(flush_a)
  );

  ex_mem_skid_reg #(.DATA_W(DATA_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP), .CNT_W(CNT_W_N)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_flush(flush), .bus(bus_b),
    .o_occ(occ_b), .o_stall_cnt(stall_b), .o_flush_cnt(flush_b)
  );

  always #5 clk = ~clk;

  beat_t       q[$];
  beat_t       shown = '{instr: NOP, data: '0};
  int unsigned stall_n = 0;
  int unsigned flush_n = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  logic        m_up_ok, m_dn_ok;

  function automatic int unsigned sat(input int unsigned n, input int w);
    int unsigned mx;
    mx = (32'd1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Queue model: at most two beats held, the head is what MEM sees.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      shown   = '{instr: NOP, data: '0};
      stall_n = 0;
      flush_n = 0;
    end else begin
      m_up_ok = up_vld && (q.size() < 2);
      m_dn_ok = (q.size() > 0) && dn_rdy;
      if ((q.size() > 0) && !dn_rdy) stall_n++;
      if (flush) begin
        if ((q.size() > 0) || up_vld) flush_n++;
        q.delete();
        shown = '{instr: NOP, data: '0};
      end else begin
        if (m_dn_ok) void'(q.pop_front());
        if (m_up_ok) q.push_back('{instr: up_instr, data: up_data});
        if (q.size() > 0) shown = q[0];
      end
    end
  end

  always @(negedge clk) begin
    chk("dn_vld",    192'(bus_a.o_dn_vld),   192'(q.size() > 0));
    chk("up_rdy",    192'(bus_a.o_up_rdy),   192'(q.size() < 2));
    chk("occ",       192'(occ_a),            192'(q.size()));
    chk("dn_instr",  192'(bus_a.o_dn_instr), 192'(shown.instr));
    chk("dn_data",   192'(bus_a.o_dn_data),  192'(shown.data));
    chk("stall_cnt", 192'(stall_a),          192'(sat(stall_n, CNT_W)));
    chk("flush_cnt", 192'(flush_a),          192'(sat(flush_n, CNT_W)));
    chk("n_instr",   192'(bus_b.o_dn_instr), 192'(shown.instr));
    chk("n_stall",   192'(stall_b),          192'(sat(stall_n, CNT_W_N)));
    chk("n_flush",   192'(flush_b),          192'(sat(flush_n, CNT_W_N)));
  end

  function automatic logic [DATA_W-1:0] pat(input logic [INSTR_W-1:0] ins);
    return {ins, {(DATA_W-64){1'b1}}, ins};
  endfunction

  task automatic set_in(input logic v, input logic [INSTR_W-1:0] ins, input logic [DATA_W-1:0] d,
                        input logic r, input logic f);
    #1;
    up_vld   = v;
    up_instr = ins;
    up_data  = d;
    dn_rdy   = r;
    flush    = f;
    @(negedge clk);
  endtask

  initial begin
    logic [DATA_W-1:0]  rd;
    logic [INSTR_W-1:0] ri;

    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_dn_instr", 192'(bus_a.o_dn_instr), 192'(32'h0000_0013));
    chk("rst_up_rdy",   192'(bus_a.o_up_rdy),   192'(1'b1));

    set_in(1'b1, 32'h50, pat(32'h50), 1'b0, 1'b0);
    set_in(1'b1, 32'h51, pat(32'h51), 1'b0, 1'b0);
    chk("fill_occ", 192'(occ_a), 192'(2'd2));
    #2 rst = 1'b1;
    #1;
    chk("async_dn_vld", 192'(bus_a.o_dn_vld),   192'(1'b0));
    chk("async_up_rdy", 192'(bus_a.o_up_rdy),   192'(1'b1));
    chk("async_occ",    192'(occ_a),            192'(2'd0));
    chk("async_instr",  192'(bus_a.o_dn_instr), 192'(32'h0000_0013));
    chk("async_data",   192'(bus_a.o_dn_data),  192'(0));
    chk("async_stall",  192'(stall_a),          192'(0));
    chk("async_flush",  192'(flush_a),          192'(0));
    @(negedge clk);
    #1 rst = 1'b0;

    for (int k = 0; k < 8; k++) begin
      set_in(1'b1, 32'h100 + k, pat(32'h100 + k), 1'b1, 1'b0);
      chk("stream_instr", 192'(bus_a.o_dn_instr), 192'(32'h100 + k));
      chk("stream_vld",   192'(bus_a.o_dn_vld),   192'(1'b1));
    end
    chk("stream_stall", 192'(stall_a), 192'(0));

    set_in(1'b1, 32'h200, pat(32'h200), 1'b0, 1'b0);
    chk("bp_occ",    192'(occ_a),            192'(2'd2));
    chk("bp_up_rdy", 192'(bus_a.o_up_rdy),   192'(1'b0));
    chk("bp_head",   192'(bus_a.o_dn_instr), 192'(32'h107));
    set_in(1'b1, 32'h201, pat(32'h201), 1'b0, 1'b0);
    set_in(1'b1, 32'h201, pat(32'h201), 1'b0, 1'b0);
    chk("bp_stall",  192'(stall_a),          192'(3));
    chk("bp_occ2",   192'(occ_a),            192'(2'd2));
    set_in(1'b1, 32'h201, pat(32'h201), 1'b1, 1'b0);
    chk("bp_skid",   192'(bus_a.o_dn_instr), 192'(32'h200));
    chk("bp_rdy_up", 192'(bus_a.o_up_rdy),   192'(1'b1));
    set_in(1'b1, 32'h201, pat(32'h201), 1'b1, 1'b0);
    chk("bp_next",   192'(bus_a.o_dn_instr), 192'(32'h201));
    set_in(1'b0, 32'h0, '0, 1'b1, 1'b0);
    chk("bp_empty",  192'(bus_a.o_dn_vld),   192'(1'b0));
    chk("bp_hold",   192'(bus_a.o_dn_instr), 192'(32'h201));

    set_in(1'b1, 32'h300, pat(32'h300), 1'b0, 1'b0);
    set_in(1'b1, 32'h301, pat(32'h301), 1'b0, 1'b0);
    set_in(1'b1, 32'h3FF, pat(32'h3FF), 1'b0, 1'b1);
    chk("fl_occ",    192'(occ_a),            192'(2'd0));
    chk("fl_instr",  192'(bus_a.o_dn_instr), 192'(32'h0000_0013));
    chk("fl_data",   192'(bus_a.o_dn_data),  192'(0));
    chk("fl_cnt",    192'(flush_a),          192'(1));
    chk("fl_stall",  192'(stall_a),          192'(5));
    set_in(1'b0, 32'h0, '0, 1'b0, 1'b1);
    chk("fl_idle",   192'(flush_a),          192'(1));
    set_in(1'b0, 32'h0, '0, 1'b1, 1'b0);
    chk("fl_gone",   192'(bus_a.o_dn_vld),   192'(1'b0));

    set_in(1'b1, 32'h400, pat(32'h400), 1'b0, 1'b0);
    repeat (20) set_in(1'b0, 32'h0, '0, 1'b0, 1'b0);
    chk("sat_wide",  192'(stall_a),          192'(25));
    chk("sat_narrow", 192'(stall_b),         192'(15));
    chk("sat_head",  192'(bus_a.o_dn_instr), 192'(32'h400));
    set_in(1'b0, 32'h0, '0, 1'b1, 1'b0);

    for (int i = 0; i < 10000; i++) begin
      rd = '0;
      for (int w = 0; w < 5; w++) rd = {rd[DATA_W-33:0], 32'($urandom())};
      ri = 32'($urandom());
      set_in(1'($urandom_range(1)), ri, rd, 1'($urandom_range(1)), ($urandom_range(99) < 2));
    end
    repeat (3) set_in(1'b0, 32'h0, '0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
